// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter with a bus watchdog.
// M0 and M1 share one slave-side port. A grant lasts for the whole CYC
// burst, and ties are broken round-robin using the `last` pointer. A transfer
// that the slave never answers is aborted with ERR after TIMEOUT_CYCLES
// unanswered strobe cycles.
module wb_arbiter_2m #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                                CLK_I,
    input  logic                                RST_NI,
    // master 0
    input  logic                                M0_CYC_I,
    input  logic                                M0_STB_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]      M0_ADR_I,
    input  logic                                M0_WE_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]       M0_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]     M0_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]       M0_DAT_O,
    output logic                                M0_ACK_O,
    output logic                                M0_ERR_O,
    // master 1
    input  logic                                M1_CYC_I,
    input  logic                                M1_STB_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]      M1_ADR_I,
    input  logic                                M1_WE_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]       M1_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]     M1_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]       M1_DAT_O,
    output logic                                M1_ACK_O,
    output logic                                M1_ERR_O,
    // slave side
    output logic                                S_CYC_O,
    output logic                                S_STB_O,
    output logic                                S_WE_O,
    output logic [WISHBONE_ADDR_WIDTH-1:0]      S_ADR_O,
    output logic [WISHBONE_BUS_WIDTH-1:0]       S_DAT_O,
    output logic [WISHBONE_BUS_WIDTH/8-1:0]     S_SEL_O,
    input  logic [WISHBONE_BUS_WIDTH-1:0]       S_DAT_I,
    input  logic                                S_ACK_I,
    input  logic                                S_ERR_I,
    // status
    output logic [1:0]                          GNT_O,
    output logic                                TIMEOUT_O
);

    localparam int AW = WISHBONE_ADDR_WIDTH;
    localparam int DW = WISHBONE_BUS_WIDTH;
    localparam int SW = WISHBONE_BUS_WIDTH / 8;
    // A zero timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    // The grant encodings double as the GNT_O value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT0  = 2'b01,
        GNT1  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic            last_reg, last_next;
    logic [WD_W-1:0] wd_reg, wd_next;

    // Indexable views of the two master ports.
    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [SW-1:0] m_sel [2];
    logic [1:0]    m_ack, m_err;
    logic [DW-1:0] m_dat_o [2];

    assign m_cyc    = {M1_CYC_I, M0_CYC_I};
    assign m_stb    = {M1_STB_I, M0_STB_I};
    assign m_we     = {M1_WE_I,  M0_WE_I};
    assign m_adr[0] = M0_ADR_I;
    assign m_adr[1] = M1_ADR_I;
    assign m_dat[0] = M0_DAT_I;
    assign m_dat[1] = M1_DAT_I;
    assign m_sel[0] = M0_SEL_I;
    assign m_sel[1] = M1_SEL_I;

    logic active;     // a master currently owns the slave port
    logic sel;        // index of the owning master
    logic cur_cyc;
    logic cur_stb;
    logic resp;       // slave answered this cycle
    logic abort;      // watchdog fires this cycle

    assign active  = (state_reg == GNT0) || (state_reg == GNT1);
    assign sel     = (state_reg == GNT1);
    assign cur_cyc = m_cyc[sel];
    assign cur_stb = m_stb[sel];
    assign resp    = S_ACK_I | S_ERR_I;
    // A response in the limit cycle wins over the abort.
    assign abort   = WD_EN && active && cur_cyc && cur_stb && !resp && (wd_reg == WD_LIMIT);

    // State, round-robin pointer and watchdog registers; reset makes M0 win the first tie.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            wd_reg    <= wd_next;
        end
    end

    // Next-state: arbitrate in IDLE, hold for the burst, abort on timeout, wait out DRAIN.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        wd_next    = wd_reg;
        case (state_reg)
            IDLE: begin
                wd_next = '0;
                if (m_cyc[0] && (!m_cyc[1] || last_reg)) begin
                    state_next = GNT0;
                end else if (m_cyc[1]) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!cur_cyc) begin
                    state_next = IDLE;
                    last_next  = sel;
                    wd_next    = '0;
                end else if (abort) begin
                    state_next = DRAIN;
                    last_next  = sel;
                    wd_next    = '0;
                end else if (resp) begin
                    wd_next = '0;
                end else if (cur_stb && (wd_reg != '1)) begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            DRAIN: begin
                wd_next = '0;
                // last_reg names the aborted master here
                if (!m_cyc[last_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output routing: connect the owner to the slave, everyone else sees zeros.
    always_comb begin
        S_CYC_O    = 1'b0;
        S_STB_O    = 1'b0;
        S_WE_O     = 1'b0;
        S_ADR_O    = '0;
        S_DAT_O    = '0;
        S_SEL_O    = '0;
        m_ack      = 2'b00;
        m_err      = 2'b00;
        m_dat_o[0] = '0;
        m_dat_o[1] = '0;
        TIMEOUT_O  = 1'b0;
        if (active) begin
            S_CYC_O      = cur_cyc & ~abort;
            S_STB_O      = cur_stb & ~abort;
            S_WE_O       = m_we[sel];
            S_ADR_O      = m_adr[sel];
            S_DAT_O      = m_dat[sel];
            S_SEL_O      = m_sel[sel];
            m_ack[sel]   = S_ACK_I;
            m_err[sel]   = S_ERR_I | abort;
            m_dat_o[sel] = S_DAT_I;
            TIMEOUT_O    = abort;
        end
    end

    assign M0_ACK_O = m_ack[0];
    assign M0_ERR_O = m_err[0];
    assign M0_DAT_O = m_dat_o[0];
    assign M1_ACK_O = m_ack[1];
    assign M1_ERR_O = m_err[1];
    assign M1_DAT_O = m_dat_o[1];

    assign GNT_O = (state_reg == GNT0) ? 2'b01 :
                   (state_reg == GNT1) ? 2'b10 : 2'b00;

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone classic arbiter with bus watchdog. It lets the CPU data-memory master (M0) and a second master (M1, e.g. a UART boot loader or DMA engine) share the single slave-side port that feeds the address-decoding interconnect (data RAM, UART). The grant is held for a whole CYC_O burst. Ties are broken round-robin. A slave that never answers is aborted with an ERR to the requesting master after a programmable number of cycles.

## Interface
Parameters:
- WISHBONE_ADDR_WIDTH, 32, address width of all ports
- WISHBONE_BUS_WIDTH, 32, data width; SEL width = WISHBONE_BUS_WIDTH/8
- TIMEOUT_CYCLES, 255, maximum wait-for-ACK/ERR cycles per transfer; 0 disables the watchdog

Ports (Mx = M0 and M1, one identical set each; "W" = WISHBONE_BUS_WIDTH, "A" = WISHBONE_ADDR_WIDTH):
- CLK_I  in  1  single clock, rising edge
- RST_NI  in  1  reset, asynchronous, active-low
- Mx_CYC_I  in  1  master cycle
- Mx_STB_I  in  1  master strobe
- Mx_ADR_I  in  A  master address
- Mx_WE_I  in  1  master write enable
- Mx_DAT_I  in  W  master write data
- Mx_SEL_I  in  W/8  master byte selects
- Mx_DAT_O  out  W  read data to master
- Mx_ACK_O  out  1  acknowledge to master
- Mx_ERR_O  out  1  error to master
- S_CYC_O, S_STB_O, S_WE_O  out  1  slave-side controls
- S_ADR_O  out  A  slave-side address
- S_DAT_O  out  W  slave-side write data
- S_SEL_O  out  W/8  slave-side byte selects
- S_DAT_I  in  W  slave read data
- S_ACK_I, S_ERR_I  in  1  slave responses
- GNT_O  out  2  one-hot current grant (bit0 = M0)
- TIMEOUT_O  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, GNT0, GNT1, DRAIN. Registered `last` pointer (0/1).
- A request is Mx_CYC_I=1.
- IDLE:
  - one requester: go to its GNTx next cycle;
  - both request: grant the master that is not `last`;
  - no requester: stay.
- GNTx:
  - S_CYC/STB/ADR/WE/DAT/SEL driven from master x combinationally;
  - Mx_ACK_O = S_ACK_I; Mx_ERR_O = S_ERR_I; Mx_DAT_O = S_DAT_I.
- Non-granted master: ACK_O = ERR_O = 0, DAT_O = 0. Its request waits.
- Leaving GNTx: when Mx_CYC_I falls, go to IDLE next cycle and set `last` = x. The other master's pending request is granted one cycle later (no back-to-back grant).
- Watchdog counter `wd`, width $clog2(TIMEOUT_CYCLES+1):
  - cleared on entering GNTx and on any S_ACK_I/S_ERR_I;
  - increments each GNTx cycle with Mx_STB_I=1 and no response;
  - saturates; frozen while STB=0.
- Abort: if TIMEOUT_CYCLES≠0 and wd == TIMEOUT_CYCLES with no response in that cycle, then in that same cycle:
  - Mx_ERR_O=1, S_CYC_O=S_STB_O=0, TIMEOUT_O=1;
  - next state DRAIN, `last` = x.
- DRAIN:
  - slave outputs idle, all master outputs 0;
  - late S_ACK_I/S_ERR_I are ignored;
  - go to IDLE once the aborted master drops CYC_I.
- In IDLE and DRAIN, S_* data/address outputs are 0.

## Timing
- Reset (RST_NI=0, async):
  - state IDLE, `last`=1 (so M0 wins the first tie), wd=0;
  - all outputs 0: S_*, Mx_*_O, GNT_O=2'b00, TIMEOUT_O=0.
- Reset mid-transfer: slave CYC drops immediately; no ACK/ERR is produced.
- Arbitration latency: 1 cycle from CYC_I rising in IDLE to S_CYC_O high.
- Response path: S_ACK_I/S_ERR_I → Mx_*_O is combinational, zero latency. Multiple STB beats within one CYC stay granted.
- GNT_O is registered and equals the state encoding (GNT0 → 01, GNT1 → 10, else 00).
- Timeout: ERR_O asserts on the (TIMEOUT_CYCLES+1)-th cycle of unanswered STB.
- Simultaneous S_ACK_I on the abort cycle: the ACK wins, no abort.
- A release (CYC_I falling) and a new request from the other master in the same cycle: IDLE first, then grant the other master.

## Test plan
- Single M0 write: M0 CYC/STB at cycle 0, ADR=0x0000_0010, DAT=0xDEADBEEF, SEL=0xF → S_CYC_O at cycle 1 carrying the same values; S_ACK_I at cycle 2 → M0_ACK_O=1 at cycle 2; GNT_O=01.
- Simultaneous first request after reset: M0 and M1 raise CYC together → M0 granted. M0 releases → M1 granted 2 cycles later; GNT_O 01→00→10.
- Round-robin fairness: both masters request continuously, 4 single-beat transfers each → grants alternate M0,M1,M0,M1…; no master is granted twice in a row.
- Watchdog with TIMEOUT_CYCLES=4: M1 read, slave never ACKs → M1_ERR_O and TIMEOUT_O high on the 5th STB cycle, S_CYC_O low that cycle. A late S_ACK_I in DRAIN is not forwarded. IDLE follows after M1 drops CYC.
- Burst hold: M0 holds CYC across 3 STB/ACK beats while M1 requests → M1_ACK_O stays 0 throughout; M1 is granted after M0 releases.
- Async reset during GNT1: RST_NI low mid-cycle → S_CYC_O and GNT_O drop without waiting for a clock. After release, M0 wins a tie.
